// File: rtl/tx_code_group_sequencer.sv
// 1000BASE-X PCS transmit code-group sequencer: turns the requested ordered set
// plus TXD into one byte/K-flag per GTX_CLK for the 8B/10B encoder.
module tx_code_group_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic [2:0]       tx_o_set,
  input  logic [7:0]       TXD,
  input  logic             tx_disparity,
  output logic [7:0]       enc_byte,
  output logic             enc_k,
  output logic             tx_even,
  output logic             TX_OSET_indicate,
  output logic             align_err,
  output logic [CNT_W-1:0] idle_cnt
);

  typedef enum logic {GEN, IDLE_2ND} state_t;

  localparam logic [2:0] OS_D = 3'd0;
  localparam logic [2:0] OS_I = 3'd1;
  localparam logic [2:0] OS_S = 3'd2;
  localparam logic [2:0] OS_T = 3'd3;
  localparam logic [2:0] OS_R = 3'd4;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  state_t           state_q;
  logic             sel_i1_q;
  logic [7:0]       enc_byte_q;
  logic             enc_k_q;
  logic             tx_even_q;
  logic             ind_q;
  logic             align_err_q;
  logic [CNT_W-1:0] idle_cnt_q;

  // Byte for every single-code-group ordered set; codes 5..7 all map to /V/.
  function automatic logic [7:0] oset_byte(input logic [2:0] os, input logic [7:0] d);
    case (os)
      OS_D:    oset_byte = d;
      OS_S:    oset_byte = 8'hFB;
      OS_T:    oset_byte = 8'hFD;
      OS_R:    oset_byte = 8'hF7;
      default: oset_byte = 8'hFE;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) sat_inc = c;
    else    sat_inc = c + CNT_W'(1);
  endfunction

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q     <= GEN;
      sel_i1_q    <= 1'b0;
      enc_byte_q  <= K28_5;
      enc_k_q     <= 1'b1;
      tx_even_q   <= 1'b0;
      ind_q       <= 1'b0;
      align_err_q <= 1'b0;
      idle_cnt_q  <= '0;
    end else begin
      ind_q       <= 1'b0;
      align_err_q <= 1'b0;
      case (state_q)
        GEN: begin
          if (tx_o_set == OS_I) begin
            // K28.5 always claims an even slot; flag it when the previous group was even too.
            enc_byte_q  <= K28_5;
            enc_k_q     <= 1'b1;
            tx_even_q   <= 1'b1;
            align_err_q <= tx_even_q;
            sel_i1_q    <= tx_disparity;
            state_q     <= IDLE_2ND;
          end else begin
            enc_byte_q <= oset_byte(tx_o_set, TXD);
            enc_k_q    <= (tx_o_set != OS_D);
            tx_even_q  <= ~tx_even_q;
            ind_q      <= 1'b1;
          end
        end
        IDLE_2ND: begin
          // Disparity was captured before K28.5 was encoded, so later changes are ignored.
          enc_byte_q <= sel_i1_q ? D5_6 : D16_2;
          enc_k_q    <= 1'b0;
          tx_even_q  <= 1'b0;
          ind_q      <= 1'b1;
          idle_cnt_q <= sat_inc(idle_cnt_q);
          state_q    <= GEN;
        end
        default: state_q <= GEN;
      endcase
    end
  end

  assign enc_byte         = enc_byte_q;
  assign enc_k            = enc_k_q;
  assign tx_even          = tx_even_q;
  assign TX_OSET_indicate = ind_q;
  assign align_err        = align_err_q;
  assign idle_cnt         = idle_cnt_q;

endmodule
